prim_flop_en_arb: RTL and testbench

Multi-requester write arbiter and sequencer for a shared enable-flop register (`prim_flop_en`). It grants one of `NumReq` writers per cycle in round-robin order. It drives the register's enable and data from the granted writer and enforces a sticky write lock. It also reports accepted writes, dropped writes and a saturating write count. It sits between several configuration masters and one shared configuration or status register.

---
 rtl/prim_flop_en_arb_pkg.sv | 14 +
 rtl/prim_flop_en_arb_if.sv | 28 ++
 rtl/prim_flop_en.sv | 31 +++
 rtl/prim_flop_en_arb.sv | 114 +++++++++++
 tb/tb_prim_flop_en_arb.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/prim_flop_en_arb_pkg.sv
// Shared types and helpers for the round-robin write arbiter in front of prim_flop_en.
package prim_flop_en_arb_pkg;

  typedef enum logic {
    Unlocked = 1'b0,
    Locked   = 1'b1
  } lock_state_e;

  // Keeps the priority pointer at least one bit wide when there is a single requester.
  function automatic int unsigned ptr_width(int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/prim_flop_en_arb_if.sv
// Requester-side and register-side signals of the write arbiter, grouped as one bundle.
interface prim_flop_en_arb_if #(
  parameter int unsigned NumReq   = 2,
  parameter int unsigned Width    = 8,
  parameter int unsigned CntWidth = 8
) ();

  logic [NumReq-1:0]            req_i;
  logic [NumReq-1:0][Width-1:0] data_i;
  logic [NumReq-1:0]            gnt_o;
  logic                         lock_i;
  logic                         locked_o;
  logic [Width-1:0]             q_o;
  logic                         upd_o;
  logic                         err_o;
  logic [CntWidth-1:0]          wr_cnt_o;

  modport master (
    output req_i, data_i, lock_i,
    input  gnt_o, locked_o, q_o, upd_o, err_o, wr_cnt_o
  );

  modport slave (
    input  req_i, data_i, lock_i,
    output gnt_o, locked_o, q_o, upd_o, err_o, wr_cnt_o
  );

endinterface

// File: rtl/prim_flop_en.sv
// Enable flop with asynchronous active-low reset to a parameterised value.
module prim_flop_en #(
  parameter int unsigned      Width      = 1,
  parameter bit               EnSecBuf   = 1'b0,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic en;

  if (EnSecBuf) begin : gen_en_buf
    // Hook for a hardened buffer cell on the enable; functionally transparent here.
    assign en = en_i;
  end else begin : gen_en_direct
    assign en = en_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_o <= ResetValue;
    end else if (en) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/prim_flop_en_arb.sv
// Round-robin write arbiter for a shared enable flop, with sticky write lock and write statistics.
module prim_flop_en_arb
  import prim_flop_en_arb_pkg::*;
#(
  parameter int unsigned      NumReq     = 2,
  parameter int unsigned      Width      = 8,
  parameter logic [Width-1:0] ResetValue = '0,
  parameter int unsigned      CntWidth   = 8
) (
  input logic               clk_i,
  input logic               rst_ni,
  prim_flop_en_arb_if.slave bus
);

  localparam int unsigned PtrW = ptr_width(NumReq);

  logic [PtrW-1:0]     ptr_q, ptr_d;
  logic [NumReq-1:0]   gnt;
  logic                any_gnt;
  logic                en;
  logic                drop;
  logic [Width-1:0]    wdata;
  lock_state_e         lock_q;
  logic                upd_q;
  logic                err_q;
  logic [CntWidth-1:0] cnt_q;
  logic [Width-1:0]    q;

  // Two passes (indices at/above ptr, then below) stand in for a rotated priority search.
  always_comb begin
    int unsigned ptr_int;
    logic        found;
    gnt     = '0;
    ptr_d   = ptr_q;
    found   = 1'b0;
    ptr_int = int'(ptr_q);
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (!found && bus.req_i[i] && (i >= ptr_int)) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
        ptr_d  = (i == NumReq - 1) ? '0 : PtrW'(i + 1);
      end
    end
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (!found && bus.req_i[i] && (i < ptr_int)) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
        ptr_d  = (i == NumReq - 1) ? '0 : PtrW'(i + 1);
      end
    end
  end

  always_comb begin
    wdata = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      wdata = wdata | (bus.data_i[i] & {Width{gnt[i]}});
    end
  end

  assign any_gnt = |gnt;
  assign en      = any_gnt & (lock_q == Unlocked);
  assign drop    = any_gnt & (lock_q == Locked);

  prim_flop_en #(
    .Width      (Width),
    .EnSecBuf   (1'b0),
    .ResetValue (ResetValue)
  ) u_flop (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (en),
    .d_i    (wdata),
    .q_o    (q)
  );

  // Pointer also advances on dropped grants so locked requesters keep rotating.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (any_gnt) begin
      ptr_q <= ptr_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q <= Unlocked;
    end else if (bus.lock_i) begin
      lock_q <= Locked;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      upd_q <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      upd_q <= en;
      err_q <= drop;
      if (en && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CntWidth'(1);
      end
    end
  end

  assign bus.gnt_o    = gnt;
  assign bus.locked_o = (lock_q == Locked);
  assign bus.q_o      = q;
  assign bus.upd_o    = upd_q;
  assign bus.err_o    = err_q;
  assign bus.wr_cnt_o = cnt_q;

endmodule

// File: tb/tb_prim_flop_en_arb.sv
// Directed self-checking bench: vector table plus reset and counter-saturation sequences.
module tb_prim_flop_en_arb;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  prim_flop_en_arb_if #(.NumReq(2), .Width(8), .CntWidth(8)) bus_a ();
  prim_flop_en_arb_if #(.NumReq(2), .Width(8), .CntWidth(2)) bus_b ();

  prim_flop_en_arb #(
    .NumReq     (2),
    .Width      (8),
    .ResetValue (8'hA5),
    .CntWidth   (8)
  ) dut_a (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_a)
  );

  prim_flop_en_arb #(
    .NumReq     (2),
    .Width      (8),
    .ResetValue (8'hA5),
    .CntWidth   (2)
  ) dut_b (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] req;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       lock;
    logic [1:0] gnt;
    logic [7:0] q;
    logic       upd;
    logic       err;
    logic       locked;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[14];
  logic [1:0] sat_exp[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;

    //            req    d0     d1     lk    gnt    q      upd   err   lkd   cnt
    vecs[0]  = '{2'b11, 8'h10, 8'h20, 1'b0, 2'b01, 8'h10, 1'b1, 1'b0, 1'b0, 8'd1};
    vecs[1]  = '{2'b11, 8'h10, 8'h20, 1'b0, 2'b10, 8'h20, 1'b1, 1'b0, 1'b0, 8'd2};
    vecs[2]  = '{2'b11, 8'h10, 8'h20, 1'b0, 2'b01, 8'h10, 1'b1, 1'b0, 1'b0, 8'd3};
    vecs[3]  = '{2'b11, 8'h10, 8'h20, 1'b0, 2'b10, 8'h20, 1'b1, 1'b0, 1'b0, 8'd4};
    vecs[4]  = '{2'b00, 8'h10, 8'h20, 1'b0, 2'b00, 8'h20, 1'b0, 1'b0, 1'b0, 8'd4};
    vecs[5]  = '{2'b01, 8'h3C, 8'h00, 1'b0, 2'b01, 8'h3C, 1'b1, 1'b0, 1'b0, 8'd5};
    vecs[6]  = '{2'b01, 8'h3C, 8'h00, 1'b0, 2'b01, 8'h3C, 1'b1, 1'b0, 1'b0, 8'd6};
    vecs[7]  = '{2'b10, 8'h3C, 8'h5A, 1'b0, 2'b10, 8'h5A, 1'b1, 1'b0, 1'b0, 8'd7};
    vecs[8]  = '{2'b10, 8'h3C, 8'h11, 1'b1, 2'b10, 8'h11, 1'b1, 1'b0, 1'b1, 8'd8};
    vecs[9]  = '{2'b01, 8'h22, 8'h11, 1'b0, 2'b01, 8'h11, 1'b0, 1'b1, 1'b1, 8'd8};
    vecs[10] = '{2'b00, 8'h22, 8'h11, 1'b0, 2'b00, 8'h11, 1'b0, 1'b0, 1'b1, 8'd8};
    vecs[11] = '{2'b11, 8'h33, 8'h44, 1'b0, 2'b10, 8'h11, 1'b0, 1'b1, 1'b1, 8'd8};
    vecs[12] = '{2'b01, 8'h33, 8'h44, 1'b0, 2'b01, 8'h11, 1'b0, 1'b1, 1'b1, 8'd8};
    vecs[13] = '{2'b00, 8'h33, 8'h44, 1'b0, 2'b00, 8'h11, 1'b0, 1'b0, 1'b1, 8'd8};

    sat_exp[0] = 2'd1;
    sat_exp[1] = 2'd2;
    sat_exp[2] = 2'd3;
    sat_exp[3] = 2'd3;
    sat_exp[4] = 2'd3;

    rst_n        = 1'b0;
    bus_a.req_i  = '0;
    bus_a.data_i = '0;
    bus_a.lock_i = 1'b0;
    bus_b.req_i  = '0;
    bus_b.data_i = '0;
    bus_b.lock_i = 1'b0;

    #12;
    rst_n = 1'b1;
    #1;
    chk("reset q", 32'(bus_a.q_o), 32'h A5);
    chk("reset cnt", 32'(bus_a.wr_cnt_o), 32'd0);
    chk("reset locked", 32'(bus_a.locked_o), 32'd0);
    chk("reset upd", 32'(bus_a.upd_o), 32'd0);
    chk("reset err", 32'(bus_a.err_o), 32'd0);

    for (int i = 0; i < 14; i++) begin
      bus_a.req_i     = vecs[i].req;
      bus_a.data_i[0] = vecs[i].d0;
      bus_a.data_i[1] = vecs[i].d1;
      bus_a.lock_i    = vecs[i].lock;
      #1;
      chk($sformatf("v%0d gnt", i), 32'(bus_a.gnt_o), 32'(vecs[i].gnt));
      @(posedge clk);
      #1;
      bus_a.lock_i = 1'b0;
      chk($sformatf("v%0d q", i), 32'(bus_a.q_o), 32'(vecs[i].q));
      chk($sformatf("v%0d upd", i), 32'(bus_a.upd_o), 32'(vecs[i].upd));
      chk($sformatf("v%0d err", i), 32'(bus_a.err_o), 32'(vecs[i].err));
      chk($sformatf("v%0d locked", i), 32'(bus_a.locked_o), 32'(vecs[i].locked));
      chk($sformatf("v%0d cnt", i), 32'(bus_a.wr_cnt_o), 32'(vecs[i].cnt));
    end

    // Reset mid-stream: block is locked and requester 1 holds priority.
    bus_a.req_i = 2'b00;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst q", 32'(bus_a.q_o), 32'h A5);
    chk("rst locked", 32'(bus_a.locked_o), 32'd0);
    chk("rst upd", 32'(bus_a.upd_o), 32'd0);
    chk("rst err", 32'(bus_a.err_o), 32'd0);
    chk("rst cnt", 32'(bus_a.wr_cnt_o), 32'd0);
    bus_a.req_i     = 2'b10;
    bus_a.data_i[1] = 8'h99;
    #1;
    chk("rst gnt comb", 32'(bus_a.gnt_o), 32'b10);
    @(posedge clk);
    #1;
    chk("rst hold q", 32'(bus_a.q_o), 32'h A5);
    chk("rst hold cnt", 32'(bus_a.wr_cnt_o), 32'd0);
    chk("rst hold upd", 32'(bus_a.upd_o), 32'd0);
    chk("rst b q", 32'(bus_b.q_o), 32'h A5);
    rst_n           = 1'b1;
    bus_a.req_i     = 2'b11;
    bus_a.data_i[0] = 8'h77;
    bus_a.data_i[1] = 8'h88;
    #1;
    chk("post rst gnt0", 32'(bus_a.gnt_o), 32'b01);
    @(posedge clk);
    #1;
    chk("post rst q0", 32'(bus_a.q_o), 32'h77);
    chk("post rst upd", 32'(bus_a.upd_o), 32'd1);
    chk("post rst cnt0", 32'(bus_a.wr_cnt_o), 32'd1);
    chk("post rst locked", 32'(bus_a.locked_o), 32'd0);
    chk("post rst gnt1", 32'(bus_a.gnt_o), 32'b10);
    @(posedge clk);
    #1;
    chk("post rst q1", 32'(bus_a.q_o), 32'h88);
    chk("post rst cnt1", 32'(bus_a.wr_cnt_o), 32'd2);
    bus_a.req_i = 2'b00;

    // Counter saturation on the 2-bit counter instance.
    for (int i = 0; i < 5; i++) begin
      bus_b.req_i     = 2'b01;
      bus_b.data_i[0] = 8'h40 + 8'(i);
      #1;
      chk($sformatf("sat%0d gnt", i), 32'(bus_b.gnt_o), 32'b01);
      @(posedge clk);
      #1;
      chk($sformatf("sat%0d cnt", i), 32'(bus_b.wr_cnt_o), 32'(sat_exp[i]));
      chk($sformatf("sat%0d q", i), 32'(bus_b.q_o), 32'(8'h40 + 8'(i)));
    end
    bus_b.req_i = 2'b00;
    @(posedge clk);
    #1;
    chk("sat idle upd", 32'(bus_b.upd_o), 32'd0);
    chk("sat idle cnt", 32'(bus_b.wr_cnt_o), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
